// File: rtl/deserializer.sv
// Serial-to-parallel receiver: reassembles MSB-first bursts of 1..16 bits into a word plus bit count.
// Define DESER_RIGHT_ALIGN_EN to right-align short words instead of left-aligning them.
module deserializer (
   input  logic        clk_i,
   input  logic        arst_n_i,
   input  logic        data_i,
   input  logic        data_val_i,
   output logic [15:0] deser_data_o,
   output logic [3:0]  deser_mod_o,
   output logic        deser_data_val_o,
   output logic        busy_o
);

   logic [15:0] r_shift;
   logic [4:0]  r_cnt;
   logic [15:0] r_data;
   logic [3:0]  r_mod;
   logic        r_data_val;
   logic        r_busy;

   logic [15:0] w_shift_next;
   logic        w_last_bit;
   logic        w_short_end;
   logic [15:0] w_short_word;

   assign w_shift_next = {r_shift[14:0], data_i};
   assign w_last_bit   = data_val_i && (r_cnt == 5'd15);
   assign w_short_end  = !data_val_i && (r_cnt != 5'd0);

`ifdef DESER_RIGHT_ALIGN_EN
   // The shift register is cleared at every termination, so it already holds zeros above the burst.
   assign w_short_word = r_shift;
`else
   logic [4:0] w_pad;
   assign w_pad        = 5'd16 - r_cnt;
   assign w_short_word = r_shift << w_pad;
`endif

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_shift    <= '0;
         r_cnt      <= '0;
         r_data     <= '0;
         r_mod      <= '0;
         r_data_val <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; the default below makes the valid a one-cycle pulse.
         r_data_val <= 1'b0;
         if (data_val_i) begin
            if (w_last_bit) begin
               r_data     <= w_shift_next;
               r_mod      <= 4'd0;
               r_data_val <= 1'b1;
               r_cnt      <= '0;
               r_shift    <= '0;
               r_busy     <= 1'b0;
            end else begin
               r_shift <= w_shift_next;
               r_cnt   <= r_cnt + 5'd1;
               r_busy  <= 1'b1;
            end
         end else if (w_short_end) begin
            r_data     <= w_short_word;
            r_mod      <= r_cnt[3:0];
            r_data_val <= 1'b1;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_busy     <= 1'b0;
         end
      end
   end

   assign deser_data_o     = r_data;
   assign deser_mod_o      = r_mod;
   assign deser_data_val_o = r_data_val;
   assign busy_o           = r_busy;

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: a burst-level model predicts each word, its count and the
// cycle of its pulse; a per-cycle compare process checks pulse, busy and payload against it.
module tb_deserializer;

   logic        clk_i = 1'b0;
   logic        arst_n_i;
   logic        data_i;
   logic        data_val_i;
   logic [15:0] deser_data_o;
   logic [3:0]  deser_mod_o;
   logic        deser_data_val_o;
   logic        busy_o;

   deserializer dut (
      .clk_i            (clk_i),
      .arst_n_i         (arst_n_i),
      .data_i           (data_i),
      .data_val_i       (data_val_i),
      .deser_data_o     (deser_data_o),
      .deser_mod_o      (deser_mod_o),
      .deser_data_val_o (deser_data_val_o),
      .busy_o           (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  mod;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] got_data[$];
   logic [3:0]  got_mod[$];
   int          got_cyc[$];

   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;
   bit   run_en  = 1'b0;
   logic exp_busy_next;
   logic exp_busy;
   logic exp_pulse;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Word a burst of n bits taken from the top of w must produce.
   function automatic logic [15:0] exp_word(input logic [15:0] w, input int n);
      if (n == 16) return w;
`ifdef DESER_RIGHT_ALIGN_EN
      return w >> (16 - n);
`else
      return w & ~(16'hFFFF >> n);
`endif
   endfunction

   always @(posedge clk_i) cyc <= cyc + 1;

   // Bits held after an edge is a property of the stimulus, so the driver announces it one edge ahead.
   always @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) exp_busy <= 1'b0;
      else           exp_busy <= exp_busy_next;
   end

   always @(negedge clk_i) begin
      if (arst_n_i && run_en) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
         exp_pulse = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
         check("pulse", {31'd0, deser_data_val_o}, {31'd0, exp_pulse});
         check("busy", {31'd0, busy_o}, {31'd0, exp_busy});
         if (deser_data_val_o) begin
            got_data.push_back(deser_data_o);
            got_mod.push_back(deser_mod_o);
            got_cyc.push_back(cyc);
         end
         if (exp_pulse) begin
            if (deser_data_val_o) begin
               check("data", {16'd0, deser_data_o}, {16'd0, exp_q[0].data});
               check("mod", {28'd0, deser_mod_o}, {28'd0, exp_q[0].mod});
            end
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk_i); #1;
         data_val_i    = 1'b0;
         data_i        = 1'b0;
         exp_busy_next = 1'b0;
      end
   endtask

   // Sends the top n bits of w MSB first; keep leaves data_val_i high for a following burst.
   task automatic send_burst(input logic [15:0] w, input int n, input bit keep);
      int   start;
      exp_t e;
      start = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i); #1;
         data_val_i    = 1'b1;
         data_i        = w[15-i];
         exp_busy_next = ((i + 1) % 16) != 0;
         if (i == 0) start = cyc;
      end
      e.data = exp_word(w, n);
      e.mod  = n[3:0];
      e.cyc  = (n == 16) ? start + 16 : start + n + 1;
      exp_q.push_back(e);
      if (!keep) idle(1);
   endtask

   int mods[14] = '{0, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
   int n0;

   initial begin
      arst_n_i      = 1'b0;
      data_i        = 1'b0;
      data_val_i    = 1'b0;
      exp_busy_next = 1'b0;
      #12;
      arst_n_i = 1'b1;
      run_en   = 1'b1;
      idle(2);

      send_burst(16'hA5C3, 16, 1'b0);
      idle(2);
      check("lit_full_data", {16'd0, got_data[got_data.size()-1]}, 32'h0000A5C3);
      check("lit_full_mod", {28'd0, got_mod[got_mod.size()-1]}, 32'd0);

      send_burst(16'hB000, 5, 1'b0);
      idle(2);
`ifdef DESER_RIGHT_ALIGN_EN
      check("lit_short_data", {16'd0, got_data[got_data.size()-1]}, 32'h00000016);
`else
      check("lit_short_data", {16'd0, got_data[got_data.size()-1]}, 32'h0000B000);
`endif
      check("lit_short_mod", {28'd0, got_mod[got_mod.size()-1]}, 32'd5);

      send_burst(16'h8000, 1, 1'b0);
      idle(2);
`ifdef DESER_RIGHT_ALIGN_EN
      check("lit_single_data", {16'd0, got_data[got_data.size()-1]}, 32'h00000001);
`else
      check("lit_single_data", {16'd0, got_data[got_data.size()-1]}, 32'h00008000);
`endif
      check("lit_single_mod", {28'd0, got_mod[got_mod.size()-1]}, 32'd1);

      n0 = got_data.size();
      send_burst(16'hFFFF, 16, 1'b1);
      send_burst(16'h0001, 16, 1'b0);
      idle(2);
      check("lit_b2b_count", got_data.size(), n0 + 2);
      check("lit_b2b_first", {16'd0, got_data[n0]}, 32'h0000FFFF);
      check("lit_b2b_second", {16'd0, got_data[n0+1]}, 32'h00000001);
      check("lit_b2b_spacing", got_cyc[n0+1] - got_cyc[n0], 16);

      // Asynchronous reset seven bits into a burst, between clock edges.
      for (int i = 0; i < 7; i++) begin
         @(posedge clk_i); #1;
         data_val_i    = 1'b1;
         data_i        = i[0];
         exp_busy_next = 1'b1;
      end
      #2;
      arst_n_i = 1'b0;
      #1;
      check("rst_data", {16'd0, deser_data_o}, 32'd0);
      check("rst_mod", {28'd0, deser_mod_o}, 32'd0);
      check("rst_val", {31'd0, deser_data_val_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      data_val_i    = 1'b0;
      data_i        = 1'b0;
      exp_busy_next = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #3;
      arst_n_i = 1'b1;
      n0 = got_data.size();
      idle(4);
      check("rst_no_pulse", got_data.size(), n0);

      // Loop-back style sweep of every serializer mode with random payloads and minimum gaps.
      foreach (mods[k]) begin
         send_burst(16'($urandom), (mods[k] == 0) ? 16 : mods[k], 1'b0);
      end
      idle(4);
      check("all_pulses_seen", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
